mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_if.sv | 20 ++
 rtl/mc_control.sv | 224 ++++++++++++++++++++++
 tb/tb_mc_control.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Memory-side handshake bundle for mc_control: instruction fetch and data access.
// The master modport is the controller; the slave modport is the memory system.
interface mc_control_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle RV64I/RV32I subset control unit: fetch, decode, execute, memory and
// write-back sequencing with ack timeouts, halt/trap states and a retire counter.
module mc_control #(
  parameter int XLEN    = 64,
  parameter int RET_W   = 64,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_control_if.master     bus,
  output logic [31:0]      inst,
  output logic [2:0]       imm_sel,
  output logic [3:0]       alu_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             pc_sel,
  output logic [1:0]       reg_w_sel,
  output logic [7:0]       mem_mask,
  output logic             reg_wen,
  output logic             pc_wen,
  output logic             halt,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [RET_W-1:0] retired,
  output logic [2:0]       state
);

  localparam int              TO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_TRAP = 3'd6
  } state_e;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic [3:0] alu_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       pc_sel;
    logic [1:0] reg_w_sel;
    logic [7:0] mem_mask;
    logic       is_mem;
    logic       is_store;
  } sel_t;

  state_e            state_q, state_d;
  logic [31:0]       inst_q, inst_d;
  sel_t              sel_q, sel_d, dec;
  logic              dec_legal, dec_ebreak;
  logic [TO_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [1:0]        cause_q, cause_d;
  logic [RET_W-1:0]  ret_q, ret_d;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [7:0]        ld_mask;

  assign opcode  = inst_q[6:0];
  assign funct3  = inst_q[14:12];
  assign cnt_inc = cnt_q + TO_W'(1);

  // Stores share the load width encoding for funct3 000..011; 64-bit widths vanish on RV32.
  always_comb begin
    dec        = '0;
    dec_legal  = 1'b0;
    dec_ebreak = (inst_q == 32'h0010_0073);
    case (funct3)
      3'b000, 3'b100: ld_mask = 8'h01;
      3'b001, 3'b101: ld_mask = 8'h03;
      3'b010:         ld_mask = 8'h0F;
      3'b110:         ld_mask = (XLEN == 64) ? 8'h0F : 8'h00;
      3'b011:         ld_mask = (XLEN == 64) ? 8'hFF : 8'h00;
      default:        ld_mask = 8'h00;
    endcase
    case (opcode)
      7'b0010011: begin
        dec_legal     = (funct3 == 3'b000);
        dec.alu_b_sel = 1'b1;
      end
      7'b1100111: begin
        dec_legal     = (funct3 == 3'b000);
        dec.alu_b_sel = 1'b1;
        dec.pc_sel    = 1'b1;
        dec.reg_w_sel = 2'd1;
      end
      7'b1101111: begin
        dec_legal     = 1'b1;
        dec.imm_sel   = 3'd4;
        dec.alu_a_sel = 1'b1;
        dec.alu_b_sel = 1'b1;
        dec.pc_sel    = 1'b1;
        dec.reg_w_sel = 2'd1;
      end
      7'b0010111: begin
        dec_legal     = 1'b1;
        dec.imm_sel   = 3'd3;
        dec.alu_a_sel = 1'b1;
        dec.alu_b_sel = 1'b1;
      end
      7'b0110111: begin
        dec_legal     = 1'b1;
        dec.imm_sel   = 3'd3;
        dec.alu_sel   = 4'd15;
        dec.alu_b_sel = 1'b1;
      end
      7'b0000011: begin
        dec_legal     = (ld_mask != 8'h00);
        dec.alu_b_sel = 1'b1;
        dec.reg_w_sel = 2'd2;
        dec.mem_mask  = ld_mask;
        dec.is_mem    = 1'b1;
      end
      7'b0100011: begin
        dec_legal     = !funct3[2] && (ld_mask != 8'h00);
        dec.imm_sel   = 3'd1;
        dec.alu_b_sel = 1'b1;
        dec.mem_mask  = ld_mask;
        dec.is_mem    = 1'b1;
        dec.is_store  = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    ret_d   = ret_q;
    case (state_q)
      S_IF: begin
        if (bus.imem_ack) begin
          inst_d  = bus.imem_rdata;
          state_d = S_ID;
        end else if ((TIMEOUT > 0) && (cnt_inc == TO_LIMIT)) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ID: begin
        if (dec_ebreak) begin
          state_d = S_HALT;
        end else if (!dec_legal) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end else begin
          sel_d   = dec;
          state_d = S_EX;
        end
      end
      S_EX: begin
        cnt_d   = '0;
        state_d = sel_q.is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          state_d = S_WB;
        end else if ((TIMEOUT > 0) && (cnt_inc == TO_LIMIT)) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
          sel_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WB: begin
        ret_d   = ret_q + RET_W'(1);
        sel_d   = '0;
        cnt_d   = '0;
        state_d = S_IF;
      end
      S_HALT, S_TRAP: state_d = state_q;
      default:        state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IF;
      inst_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      cause_q <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.imem_req = (state_q == S_IF);
  assign bus.dmem_req = (state_q == S_MEM);
  assign bus.dmem_we  = (state_q == S_MEM) && sel_q.is_store;
  assign inst         = inst_q;
  assign imm_sel      = sel_q.imm_sel;
  assign alu_sel      = sel_q.alu_sel;
  assign alu_a_sel    = sel_q.alu_a_sel;
  assign alu_b_sel    = sel_q.alu_b_sel;
  assign pc_sel       = sel_q.pc_sel;
  assign reg_w_sel    = sel_q.reg_w_sel;
  assign mem_mask     = sel_q.mem_mask;
  assign pc_wen       = (state_q == S_WB);
  assign reg_wen      = (state_q == S_WB) && !sel_q.is_store;
  assign halt         = (state_q == S_HALT);
  assign trap         = (state_q == S_TRAP);
  assign trap_cause   = cause_q;
  assign retired      = ret_q;
  assign state        = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a 64-bit instance (RET_W=4, TIMEOUT=4) and a 32-bit
// instance in lockstep; per-instruction expectations are queued and popped at write-back.
module tb_mc_control;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2, ST_MEM = 3'd3,
                         ST_WB = 3'd4, ST_HALT = 3'd5, ST_TRAP = 3'd6;

  mc_control_if bus_a ();
  mc_control_if bus_b ();

  logic [31:0] inst_a, inst_b;
  logic [2:0]  imm_sel_a, imm_sel_b, state_a, state_b;
  logic [3:0]  alu_sel_a, alu_sel_b, retired_a, retired_b;
  logic        alu_a_sel_a, alu_a_sel_b, alu_b_sel_a, alu_b_sel_b, pc_sel_a, pc_sel_b;
  logic [1:0]  reg_w_sel_a, reg_w_sel_b, trap_cause_a, trap_cause_b;
  logic [7:0]  mem_mask_a, mem_mask_b;
  logic        reg_wen_a, reg_wen_b, pc_wen_a, pc_wen_b, halt_a, halt_b, trap_a, trap_b;

  assign bus_b.imem_ack   = bus_a.imem_ack;
  assign bus_b.imem_rdata = bus_a.imem_rdata;
  assign bus_b.dmem_ack   = bus_a.dmem_ack;

  mc_control #(.XLEN(64), .RET_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .inst(inst_a), .imm_sel(imm_sel_a),
    .alu_sel(alu_sel_a), .alu_a_sel(alu_a_sel_a), .alu_b_sel(alu_b_sel_a),
    .pc_sel(pc_sel_a), .reg_w_sel(reg_w_sel_a), .mem_mask(mem_mask_a),
    .reg_wen(reg_wen_a), .pc_wen(pc_wen_a), .halt(halt_a), .trap(trap_a),
    .trap_cause(trap_cause_a), .retired(retired_a), .state(state_a)
  );

  mc_control #(.XLEN(32), .RET_W(4), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .inst(inst_b), .imm_sel(imm_sel_b),
    .alu_sel(alu_sel_b), .alu_a_sel(alu_a_sel_b), .alu_b_sel(alu_b_sel_b),
    .pc_sel(pc_sel_b), .reg_w_sel(reg_w_sel_b), .mem_mask(mem_mask_b),
    .reg_wen(reg_wen_b), .pc_wen(pc_wen_b), .halt(halt_b), .trap(trap_b),
    .trap_cause(trap_cause_b), .retired(retired_b), .state(state_b)
  );

  typedef struct packed {
    logic [63:0] seq;
    logic [7:0]  lat;
    logic        reg_wen;
    logic [1:0]  w;
    logic        pc;
    logic [2:0]  imm;
    logic        a;
    logic        b;
    logic [3:0]  alu;
    logic [7:0]  mask;
    logic        we;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_ret  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-written expectations for each instruction word used below.
  function automatic exp_t expect_for(input logic [31:0] ins, input int dly);
    exp_t e;
    logic mem;
    e = '0;
    e.b = 1'b1;
    mem = 1'b0;
    case (ins)
      32'h00500093: e.reg_wen = 1'b1;                                                    // addi
      32'h000100E7: begin e.reg_wen = 1'b1; e.pc = 1'b1; e.w = 2'd1; end                 // jalr
      32'h008000EF: begin e.reg_wen = 1'b1; e.pc = 1'b1; e.w = 2'd1; e.imm = 3'd4; e.a = 1'b1; end
      32'h00001097: begin e.reg_wen = 1'b1; e.imm = 3'd3; e.a = 1'b1; end                // auipc
      32'h123450B7: begin e.reg_wen = 1'b1; e.imm = 3'd3; e.alu = 4'd15; end             // lui
      32'h00010083: begin e.reg_wen = 1'b1; e.w = 2'd2; e.mask = 8'h01; mem = 1'b1; end  // lb
      32'h00015083: begin e.reg_wen = 1'b1; e.w = 2'd2; e.mask = 8'h03; mem = 1'b1; end  // lhu
      32'h00012083: begin e.reg_wen = 1'b1; e.w = 2'd2; e.mask = 8'h0F; mem = 1'b1; end  // lw
      32'h00013083: begin e.reg_wen = 1'b1; e.w = 2'd2; e.mask = 8'hFF; mem = 1'b1; end  // ld
      32'h00111023: begin e.imm = 3'd1; e.mask = 8'h03; e.we = 1'b1; mem = 1'b1; end     // sh
      32'h00113023: begin e.imm = 3'd1; e.mask = 8'hFF; e.we = 1'b1; mem = 1'b1; end     // sd
      default: e.b = 1'b0;
    endcase
    e.lat = 8'(dly + (mem ? 5 : 4));
    e.seq = 64'(ST_IF);
    e.seq = (e.seq << 3) | 64'(ST_ID);
    e.seq = (e.seq << 3) | 64'(ST_EX);
    if (mem) for (int i = 0; i <= dly; i++) e.seq = (e.seq << 3) | 64'(ST_MEM);
    e.seq = (e.seq << 3) | 64'(ST_WB);
    return e;
  endfunction

  task automatic run_inst(input string nm, input logic [31:0] ins, input int dly);
    exp_t e;
    int   cyc, mcyc, rgw;
    logic we_seen, done;
    logic [63:0] seq;
    sb_q.push_back(expect_for(ins, dly));
    bus_a.imem_rdata = ins;
    bus_a.imem_ack   = 1'b1;
    bus_a.dmem_ack   = 1'b0;
    cyc = 1; mcyc = 0; rgw = 0; we_seen = 1'b0; done = 1'b0;
    e = '0;
    seq = 64'(state_a);
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      bus_a.imem_ack = 1'b0;
      seq = (seq << 3) | 64'(state_a);
      if (state_a == ST_MEM) begin
        mcyc++;
        if (bus_a.dmem_we) we_seen = 1'b1;
        bus_a.dmem_ack = (mcyc > dly);
      end else begin
        bus_a.dmem_ack = 1'b0;
      end
      if (reg_wen_a) rgw++;
      if (pc_wen_a) begin
        done = 1'b1;
        e = sb_q.pop_front();
        chk({nm, "_lat"},     64'(cyc),         64'(e.lat));
        chk({nm, "_seq"},     seq,              e.seq);
        chk({nm, "_reg_wen"}, 64'(reg_wen_a),   64'(e.reg_wen));
        chk({nm, "_w_sel"},   64'(reg_w_sel_a), 64'(e.w));
        chk({nm, "_pc_sel"},  64'(pc_sel_a),    64'(e.pc));
        chk({nm, "_imm_sel"}, 64'(imm_sel_a),   64'(e.imm));
        chk({nm, "_a_sel"},   64'(alu_a_sel_a), 64'(e.a));
        chk({nm, "_b_sel"},   64'(alu_b_sel_a), 64'(e.b));
        chk({nm, "_alu_sel"}, 64'(alu_sel_a),   64'(e.alu));
        chk({nm, "_mask"},    64'(mem_mask_a),  64'(e.mask));
        chk({nm, "_we"},      64'(we_seen),     64'(e.we));
        chk({nm, "_ret_wb"},  64'(retired_a),   64'(exp_ret));
      end
    end
    if (!done) begin
      e = sb_q.pop_front();
      chk({nm, "_wb_reached"}, 64'(0), 64'(1));
    end
    tick();
    exp_ret = (exp_ret + 1) % 16;
    chk({nm, "_rgw_cnt"},  64'(rgw),        64'(e.reg_wen));
    chk({nm, "_pc_wen0"},  64'(pc_wen_a),   64'(0));
    chk({nm, "_state_if"}, 64'(state_a),    64'(ST_IF));
    chk({nm, "_retired"},  64'(retired_a),  64'(exp_ret));
    chk({nm, "_mask_clr"}, 64'(mem_mask_a), 64'(0));
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_state"},   64'(state_a),         64'(ST_IF));
    chk({nm, "_inst"},    64'(inst_a),          64'(0));
    chk({nm, "_sels"},    64'({imm_sel_a, alu_sel_a, alu_a_sel_a, alu_b_sel_a, pc_sel_a, reg_w_sel_a}), 64'(0));
    chk({nm, "_mask"},    64'(mem_mask_a),      64'(0));
    chk({nm, "_strobes"}, 64'({reg_wen_a, pc_wen_a}), 64'(0));
    chk({nm, "_halt"},    64'(halt_a),          64'(0));
    chk({nm, "_trap"},    64'(trap_a),          64'(0));
    chk({nm, "_cause"},   64'(trap_cause_a),    64'(0));
    chk({nm, "_retired"}, 64'(retired_a),       64'(0));
    chk({nm, "_dmem"},    64'({bus_a.dmem_req, bus_a.dmem_we}), 64'(0));
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    bus_a.imem_ack = 1'b0;
    bus_a.dmem_ack = 1'b0;
    bus_a.imem_rdata = 32'h0;
    tick();
    tick();
    check_reset(nm);
    rst_n = 1'b1;
    exp_ret = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mc;
    rst_n = 1'b0;
    do_reset("reset");
    chk("reset_imem_req", 64'(bus_a.imem_req), 64'(1));

    run_inst("addi", 32'h00500093, 0);
    run_inst("sd",   32'h00113023, 3);
    chk("rv32_sd_state", 64'(state_b),      64'(ST_TRAP));
    chk("rv32_sd_trap",  64'(trap_b),       64'(1));
    chk("rv32_sd_cause", 64'(trap_cause_b), 64'(1));
    chk("rv32_sd_ret",   64'(retired_b),    64'(1));
    run_inst("jal",   32'h008000EF, 0);
    run_inst("jalr",  32'h000100E7, 0);
    run_inst("auipc", 32'h00001097, 0);
    run_inst("lui",   32'h123450B7, 0);
    run_inst("lb",    32'h00010083, 0);
    run_inst("lhu",   32'h00015083, 2);
    run_inst("lw",    32'h00012083, 0);
    run_inst("ld",    32'h00013083, 1);
    run_inst("sh",    32'h00111023, 0);

    // ebreak: halt is absorbing and ignores any acks
    bus_a.imem_rdata = 32'h00100073;
    bus_a.imem_ack = 1'b1;
    tick();
    bus_a.imem_ack = 1'b0;
    chk("ebreak_id", 64'(state_a), 64'(ST_ID));
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("halt_state", 64'(state_a), 64'(ST_HALT));
      chk("halt_flag",  64'(halt_a),  64'(1));
      chk("halt_quiet", 64'({bus_a.imem_req, bus_a.dmem_req, reg_wen_a, pc_wen_a, trap_a}), 64'(0));
      chk("halt_ret",   64'(retired_a), 64'(exp_ret));
      bus_a.imem_ack = 1'($urandom_range(0, 1));
      bus_a.dmem_ack = 1'($urandom_range(0, 1));
      tick();
    end

    do_reset("rst_after_halt");
    bus_a.imem_rdata = 32'hFFFFFFFF;
    bus_a.imem_ack = 1'b1;
    tick();
    bus_a.imem_ack = 1'b0;
    tick();
    chk("illegal_state", 64'(state_a),      64'(ST_TRAP));
    chk("illegal_cause", 64'(trap_cause_a), 64'(1));
    chk("illegal_flags", 64'({halt_a, trap_a}), 64'(1));
    chk("illegal_ret",   64'(retired_a),    64'(0));

    do_reset("rst_after_illegal");
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("if_wait_state", 64'(state_a), 64'(ST_IF));
    end
    tick();
    chk("if_to_state", 64'(state_a),        64'(ST_TRAP));
    chk("if_to_cause", 64'(trap_cause_a),   64'(2));
    chk("if_to_trap",  64'(trap_a),         64'(1));
    chk("if_to_req",   64'(bus_a.imem_req), 64'(0));
    rst_n = 1'b0;
    tick();
    check_reset("rst_after_if_to");
    rst_n = 1'b1;
    tick();
    chk("rst_release_req",   64'(bus_a.imem_req), 64'(1));
    chk("rst_release_state", 64'(state_a),        64'(ST_IF));

    // load whose dmem ack never arrives
    bus_a.imem_rdata = 32'h00012083;
    bus_a.imem_ack = 1'b1;
    tick();
    bus_a.imem_ack = 1'b0;
    tick();
    tick();
    chk("mem_to_req", 64'(bus_a.dmem_req), 64'(1));
    mc = 1;
    while (state_a == ST_MEM && mc < 20) begin
      tick();
      if (state_a == ST_MEM) mc++;
    end
    chk("mem_to_cycles", 64'(mc),           64'(4));
    chk("mem_to_state",  64'(state_a),      64'(ST_TRAP));
    chk("mem_to_cause",  64'(trap_cause_a), 64'(3));
    chk("mem_to_ret",    64'(retired_a),    64'(0));

    // reset in the middle of a data handshake
    do_reset("rst_after_mem_to");
    bus_a.imem_rdata = 32'h00113023;
    bus_a.imem_ack = 1'b1;
    tick();
    bus_a.imem_ack = 1'b0;
    tick();
    tick();
    chk("mid_mem_state", 64'(state_a), 64'(ST_MEM));
    rst_n = 1'b0;
    tick();
    check_reset("mid_mem_rst");
    rst_n = 1'b1;
    tick();
    chk("mid_mem_req", 64'({bus_a.imem_req, bus_a.dmem_req}), 64'(2));

    do_reset("rst_wrap");
    for (int i = 0; i < 17; i++) run_inst("wrap_addi", 32'h00500093, 0);
    chk("wrap_retired", 64'(retired_a), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
